// File: rtl/out_code_buffer_pkg.sv
// Shared output-code definitions for the Mealy FSM and its output buffer.
// Holds the Y0..Y4 code constants, the code width and the illegal-code test.
package out_code_buffer_pkg;

  localparam int CODE_W = 3;

  typedef enum logic [CODE_W-1:0] {
    Y0 = 3'b000,
    Y1 = 3'b001,
    Y2 = 3'b010,
    Y3 = 3'b011,
    Y4 = 3'b100
  } out_code_e;

  function automatic logic is_illegal(
    input logic [CODE_W-1:0] c
  );
    return (c > Y4);
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// DEPTH x CODE_W storage with wrapping pointers and an occupancy counter.
// Ports: clk/rst_n, i_clr flush, i_push/i_wdata, i_pop, o_rdata (head), o_count/o_empty/o_full.
module sync_fifo_core
  import out_code_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [CODE_W-1:0] i_wdata,
  output logic [CODE_W-1:0] o_rdata,
  output logic [AW:0]       o_count,
  output logic              o_empty,
  output logic              o_full
);

  logic [CODE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; stale entries are never readable.
  always_ff @(posedge clk) begin
    if (i_push && !i_clr) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/out_code_buffer.sv
// FIFO buffer for FSM output codes with overflow/illegal-code flags and Y4 counter.
// Ports: clk, reset (async low), code_in/code_valid, rd_en, clr; rd_data/rd_valid, status, flags, y4_cnt.
module out_code_buffer
  import out_code_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CODE_W-1:0]        code_in,
  input  logic                     code_valid,
  input  logic                     rd_en,
  input  logic                     clr,
  output logic [CODE_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     err_code,
  output logic [CNT_W-1:0]         y4_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic              w_illegal;
  logic              w_legal;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_empty;
  logic              w_full;
  logic [AW:0]       w_count;
  logic [CODE_W-1:0] w_head;

  logic [CODE_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_overflow;
  logic              r_err_code;
  logic [CNT_W-1:0]  r_y4_cnt;

  assign w_illegal = code_valid && is_illegal(code_in);
  assign w_legal   = code_valid && !is_illegal(code_in);
  assign w_pop     = rd_en && !w_empty;
  // A pop in the same cycle frees the slot a full buffer needs.
  assign w_push    = w_legal && (!w_full || w_pop);
  assign w_drop    = w_legal && w_full && !w_pop;

  sync_fifo_core #(
    .DEPTH (DEPTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (reset),
    .i_clr   (clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (code_in),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_overflow <= 1'b0;
      r_err_code <= 1'b0;
      r_y4_cnt   <= '0;
    end else if (clr) begin
      r_rd_valid <= 1'b0;
      r_overflow <= 1'b0;
      r_err_code <= 1'b0;
      r_y4_cnt   <= '0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop)     r_rd_data  <= w_head;
      if (w_drop)    r_overflow <= 1'b1;
      if (w_illegal) r_err_code <= 1'b1;
      if (w_push && code_in == Y4 && r_y4_cnt != '1)
        r_y4_cnt <= r_y4_cnt + CNT_W'(1);
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = w_count;
  assign overflow = r_overflow;
  assign err_code = r_err_code;
  assign y4_cnt   = r_y4_cnt;

endmodule

// File: tb/tb_out_code_buffer.sv
// Scoreboard bench for out_code_buffer: stimulus queues expected pops,
// a negedge monitor compares every rd_valid beat against the queue.
module tb_out_code_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] code_in = '0;
  logic       code_valid = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overflow;
  logic       err_code;
  logic [7:0] y4_cnt;

  int checks = 0;
  int failures = 0;
  logic [2:0] exp_q [$];

  out_code_buffer #(.DEPTH(8), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .code_in    (code_in),
    .code_valid (code_valid),
    .rd_en      (rd_en),
    .clr        (clr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overflow   (overflow),
    .err_code   (err_code),
    .y4_cnt     (y4_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every rd_valid beat must match the oldest expected code.
  always @(negedge clk) begin
    if (reset && rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rd_valid: got data %0d expected no pop", rd_data);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        chk("rd_data", int'(rd_data), int'(e));
      end
    end
  end

  task automatic step(input logic v, input logic [2:0] c,
                      input logic r, input logic cl);
    code_valid = v;
    code_in    = c;
    rd_en      = r;
    clr        = cl;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    rd_en      = 1'b0;
    clr        = 1'b0;
  endtask

  task automatic push(input logic [2:0] c);
    step(1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic pop(input logic [2:0] e);
    exp_q.push_back(e);
    step(1'b0, 3'b000, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] fill [8];
    fill = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2};

    #12;
    chk("rst_empty", int'(empty), 1);
    chk("rst_count", int'(count), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // In-order pop of four codes
    push(3'b001); push(3'b011); push(3'b100); push(3'b010);
    chk("t1_count", int'(count), 4);
    pop(3'b001); pop(3'b011); pop(3'b100); pop(3'b010);
    chk("t1_empty", int'(empty), 1);
    chk("t1_y4", int'(y4_cnt), 1);
    // Pop while empty is ignored: monitor flags any rd_valid
    step(1'b0, 3'b000, 1'b1, 1'b0);
    chk("t1_rdata_hold", int'(rd_data), 2);

    // Fill, then overflow
    for (int i = 0; i < 8; i++) push(3'b001);
    chk("t2_full", int'(full), 1);
    chk("t2_ovf_before", int'(overflow), 0);
    push(3'b001);
    chk("t2_ovf", int'(overflow), 1);
    chk("t2_count", int'(count), 8);
    for (int i = 0; i < 8; i++) pop(3'b001);
    chk("t2_empty", int'(empty), 1);
    chk("t2_ovf_sticky", int'(overflow), 1);
    step(1'b0, 3'b000, 1'b0, 1'b1);
    chk("t2_clr_ovf", int'(overflow), 0);

    // Push+pop while full
    for (int i = 0; i < 8; i++) push(fill[i]);
    exp_q.push_back(3'd0);
    step(1'b1, 3'b100, 1'b1, 1'b0);
    chk("t3_count", int'(count), 8);
    chk("t3_ovf", int'(overflow), 0);
    chk("t3_y4", int'(y4_cnt), 2);
    for (int i = 1; i < 8; i++) pop(fill[i]);
    pop(3'b100);
    chk("t3_empty", int'(empty), 1);

    // Illegal codes and clr priority
    step(1'b0, 3'b000, 1'b0, 1'b1);
    push(3'b100);
    step(1'b1, 3'b101, 1'b0, 1'b0);
    step(1'b1, 3'b111, 1'b0, 1'b0);
    chk("t4_err", int'(err_code), 1);
    chk("t4_count", int'(count), 1);
    chk("t4_y4", int'(y4_cnt), 1);
    step(1'b1, 3'b100, 1'b1, 1'b1);
    chk("t4_clr_err", int'(err_code), 0);
    chk("t4_clr_count", int'(count), 0);
    chk("t4_clr_y4", int'(y4_cnt), 0);
    chk("t4_clr_rd_valid", int'(rd_valid), 0);

    // Y4 saturation
    push(3'b100);
    for (int i = 1; i < 300; i++) begin
      exp_q.push_back(3'b100);
      step(1'b1, 3'b100, 1'b1, 1'b0);
      if (i == 199) chk("t5_y4_mid", int'(y4_cnt), 200);
    end
    chk("t5_y4_sat", int'(y4_cnt), 255);
    chk("t5_count", int'(count), 1);
    pop(3'b100);
    chk("t5_y4_hold", int'(y4_cnt), 255);

    // Asynchronous reset mid-operation
    push(3'b001); push(3'b010); push(3'b011);
    chk("t6_count_pre", int'(count), 3);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_empty", int'(empty), 1);
    chk("t6_count", int'(count), 0);
    chk("t6_rd_data", int'(rd_data), 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 3'b000, 1'b1, 1'b0);
    chk("t6_rd_valid", int'(rd_valid), 0);

    idle(2);
    chk("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/out_code_buffer.md
OUT_CODE_BUFFER -- requirements
Module: out_code_buffer

Interface
REQ-001 Parameter DEPTH, default 8, number of buffer entries (power of two, 2..16).
REQ-002 Parameter CNT_W, default 8, width of the Y4 event counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset; all registers take reset values while reset=0.
REQ-005 code_in  input  3  output code from the upstream Mealy FSM (Y0=000 .. Y4=100).
REQ-006 code_valid  input  1  code_in is sampled this cycle.
REQ-007 rd_en  input  1  consumer pops one entry this cycle.
REQ-008 clr  input  1  synchronous flush of buffer, flags and counter.
REQ-009 rd_data  output  3  most recently popped code, registered.
REQ-010 rd_valid  output  1  one-cycle pulse: rd_data was updated this cycle.
REQ-011 empty  output  1  buffer holds 0 entries.
REQ-012 full  output  1  buffer holds DEPTH entries.
REQ-013 count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 overflow  output  1  sticky: a valid code was dropped because the buffer was full.
REQ-015 err_code  output  1  sticky: an illegal code (101, 110, 111) was presented with code_valid=1.
REQ-016 y4_cnt  output  CNT_W  saturating count of accepted Y4 codes.

Function
REQ-017 Buffer is first-in first-out; pop order equals push order.
REQ-018 Push occurs when code_valid=1, code_in<=100, and (full=0 or a pop occurs in the same cycle).
REQ-019 Pop occurs when rd_en=1 and empty=0; rd_en while empty is ignored, rd_data holds, rd_valid=0.
REQ-020 Pop latency: rd_data and rd_valid=1 appear the clock edge at which rd_en is sampled; rd_data holds between pops.
REQ-021 Simultaneous push and pop while full: both performed, count unchanged, overflow not set.
REQ-022 Simultaneous push and pop while empty: push only, count becomes 1, rd_valid=0.
REQ-023 Simultaneous push and pop otherwise: both performed, count unchanged.
REQ-024 Valid legal code while full without pop: code dropped, overflow set to 1, contents unchanged.
REQ-025 Illegal code with code_valid=1: not stored, err_code set to 1, other state unaffected.
REQ-026 y4_cnt increments by 1 on each pushed Y4; holds at 2^CNT_W-1 (no wrap).
REQ-027 Read/write pointers wrap modulo DEPTH; full/empty derived from count, never from pointer equality alone.
REQ-028 clr=1 has priority over push and pop: count=0, pointers=0, overflow=0, err_code=0, y4_cnt=0, rd_valid=0; rd_data holds.
REQ-029 Sticky flags cleared only by clr or reset.

Reset
REQ-030 On reset=0: rd_data=000, rd_valid=0, empty=1, full=0, count=0, overflow=0, err_code=0, y4_cnt=0, pointers=0.
REQ-031 Reset asserted mid-operation discards all stored entries immediately, without waiting for a clock edge.
REQ-032 Storage array contents need not be reset; unread entries are never observable.

Structure
REQ-033 Output code constants Y0..Y4 and the illegal-code test belong in the shared package used by the FSM and this block.
REQ-034 Storage and pointers are in one sub-module, sync_fifo_core (DEPTH x 3-bit, push/pop/count); flags and counter live in the top.

Verification
REQ-035 Push 001,011,100,010 (one per cycle), then 4 pops -> rd_data 001,011,100,010 on successive cycles, rd_valid=1 each, empty=1 after, y4_cnt=1.
REQ-036 Push 9 codes of 001 without pop -> full=1 after 8th, overflow=1 after 9th, count=8; pop all 8 -> eight 001.
REQ-037 Fill to 8, then push 100 with rd_en=1 same cycle -> count stays 8, overflow=0, last pop returns 100 after 8 more pops.
REQ-038 code_valid=1 with code_in=101 then 111 -> err_code=1, count unchanged, y4_cnt unchanged; clr=1 -> err_code=0.
REQ-039 Push 300 Y4 codes with pops (CNT_W=8) -> y4_cnt=255 and holds.
REQ-040 Push 3 entries, drive reset=0 between edges -> empty=1, count=0, rd_data=000 immediately; rd_en after release -> rd_valid=0.
